// File: rtl/clahe_frame_sched.sv
// clahe_frame_sched: frame-level sequencer for the 64-tile ping-pong
// histogram/CDF RAM. Gates histogram statistics during active video. After
// each accepted frame_end it walks every tile through the CDF engine, then
// clears the old mapping bank, and finally swaps the bank roles. That order
// matters: clearing after the swap would wipe the freshly built LUTs.
module clahe_frame_sched #(
  parameter int TILE_NUM   = 64,
  parameter int TILE_IDX_W = 6,
  parameter int FCNT_W     = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_end,
  input  logic                  clear_done,
  input  logic                  cdf_done,
  output logic                  clear_start,
  output logic                  ping_pong_flag,
  output logic                  stat_en,
  output logic                  cdf_start,
  output logic [TILE_IDX_W-1:0] cdf_tile_idx,
  output logic                  busy,
  output logic                  lut_valid,
  output logic                  overrun,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam logic [2:0] ST_INIT_WAIT = 3'd0;
  localparam logic [2:0] ST_STAT      = 3'd1;
  localparam logic [2:0] ST_CDF_REQ   = 3'd2;
  localparam logic [2:0] ST_CDF_WAIT  = 3'd3;
  localparam logic [2:0] ST_CLR_REQ   = 3'd4;
  localparam logic [2:0] ST_CLR_GAP   = 3'd5;
  localparam logic [2:0] ST_CLR_WAIT  = 3'd6;
  localparam logic [2:0] ST_SWAP      = 3'd7;

  localparam logic [TILE_IDX_W-1:0] LAST_TILE = TILE_IDX_W'(TILE_NUM - 1);
  localparam logic [TILE_IDX_W-1:0] TILE_ZERO = '0;
  localparam logic [TILE_IDX_W-1:0] TILE_ONE  = TILE_IDX_W'(1);
  localparam logic [FCNT_W-1:0]     FCNT_ZERO = '0;
  localparam logic [FCNT_W-1:0]     FCNT_ONE  = FCNT_W'(1);

  logic [2:0]            state_r;
  logic [2:0]            next_s;
  logic                  frame_acc_s;
  logic                  clear_start_r;
  logic                  ping_pong_flag_r;
  logic                  stat_en_r;
  logic                  cdf_start_r;
  logic [TILE_IDX_W-1:0] tile_r;
  logic                  busy_r;
  logic                  lut_valid_r;
  logic                  overrun_r;
  logic [FCNT_W-1:0]     frame_cnt_r;

  assign frame_acc_s    = frame_end & enable;
  assign clear_start    = clear_start_r;
  assign ping_pong_flag = ping_pong_flag_r;
  assign stat_en        = stat_en_r;
  assign cdf_start      = cdf_start_r;
  assign cdf_tile_idx   = tile_r;
  assign busy           = busy_r;
  assign lut_valid      = lut_valid_r;
  assign overrun        = overrun_r;
  assign frame_cnt      = frame_cnt_r;

  // Next-state decode of the frame sequencer.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_INIT_WAIT: begin
        if (clear_done) begin
          next_s = ST_STAT;
        end else begin
          next_s = ST_INIT_WAIT;
        end
      end
      ST_STAT: begin
        if (frame_acc_s) begin
          next_s = ST_CDF_REQ;
        end else begin
          next_s = ST_STAT;
        end
      end
      ST_CDF_REQ: next_s = ST_CDF_WAIT;
      ST_CDF_WAIT: begin
        if (cdf_done) begin
          if (tile_r == LAST_TILE) begin
            next_s = ST_CLR_REQ;
          end else begin
            next_s = ST_CDF_REQ;
          end
        end else begin
          next_s = ST_CDF_WAIT;
        end
      end
      ST_CLR_REQ: next_s = ST_CLR_GAP;
      // The RAM only reports busy one cycle after clear_start, so clear_done
      // is not trusted until CLR_WAIT.
      ST_CLR_GAP: next_s = ST_CLR_WAIT;
      ST_CLR_WAIT: begin
        if (clear_done) begin
          next_s = ST_SWAP;
        end else begin
          next_s = ST_CLR_WAIT;
        end
      end
      ST_SWAP: next_s = ST_STAT;
      default: next_s = ST_INIT_WAIT;
    endcase
  end

  // State register plus the per-state strobes derived from it.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r       <= ST_INIT_WAIT;
      stat_en_r     <= 1'b0;
      busy_r        <= 1'b1;
      cdf_start_r   <= 1'b0;
      clear_start_r <= 1'b0;
    end else begin
      state_r       <= next_s;
      stat_en_r     <= (next_s == ST_STAT);
      busy_r        <= (next_s != ST_STAT);
      // cdf_start follows the request state by one cycle, so the engine sees
      // the index that was already stable during CDF_REQ.
      cdf_start_r   <= (state_r == ST_CDF_REQ);
      clear_start_r <= (next_s == ST_CLR_REQ);
    end
  end

  // Tile counter: restarts on each accepted frame, advances on cdf_done.
  always_ff @(posedge pclk) begin
    if (rst) begin
      tile_r <= TILE_ZERO;
    end else if ((state_r == ST_STAT) && frame_acc_s) begin
      tile_r <= TILE_ZERO;
    end else if ((state_r == ST_CDF_WAIT) && cdf_done) begin
      if (tile_r == LAST_TILE) begin
        tile_r <= TILE_ZERO;
      end else begin
        tile_r <= tile_r + TILE_ONE;
      end
    end else begin
      tile_r <= tile_r;
    end
  end

  // Bank swap bookkeeping: flag toggle, swap count and LUT-valid latch.
  always_ff @(posedge pclk) begin
    if (rst) begin
      ping_pong_flag_r <= 1'b0;
      frame_cnt_r      <= FCNT_ZERO;
      lut_valid_r      <= 1'b0;
    end else if (state_r == ST_SWAP) begin
      ping_pong_flag_r <= ~ping_pong_flag_r;
      frame_cnt_r      <= frame_cnt_r + FCNT_ONE;
      lut_valid_r      <= 1'b1;
    end else begin
      ping_pong_flag_r <= ping_pong_flag_r;
      frame_cnt_r      <= frame_cnt_r;
      lut_valid_r      <= lut_valid_r;
    end
  end

  // Sticky overrun: a frame_end that arrives while a pass is still running.
  always_ff @(posedge pclk) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (frame_acc_s && (state_r != ST_STAT)) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

endmodule

// File: tb/tb_clahe_frame_sched.sv
// tb_clahe_frame_sched: scoreboard bench for the CLAHE frame sequencer with
// small behavioural models of the CDF engine and the RAM clear engine.
module tb_clahe_frame_sched;

  logic        pclk;
  logic        rst;
  logic        enable;
  logic        frame_end;
  logic        clear_done;
  logic        cdf_done;
  logic        clear_start;
  logic        ping_pong_flag;
  logic        stat_en;
  logic        cdf_start;
  logic [5:0]  cdf_tile_idx;
  logic        busy;
  logic        lut_valid;
  logic        overrun;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // scoreboard: expected tile order and expected {flag, frame_cnt} per swap
  logic [5:0]  exp_tiles[$];
  logic [16:0] exp_swaps[$];
  logic        m_flag;
  logic [15:0] m_fcnt;

  // model controls and monitor bookkeeping
  int   clr_force;
  int   clr_hold;
  int   clr_low;
  int   clr_hcnt;
  int   clr_lcnt;
  int   cdf_cnt;
  int   clr_since_swap;
  int   clr_cyc;
  int   cdf_start_cnt;
  logic prev_flag;

  clahe_frame_sched dut (
    .pclk           (pclk),
    .rst            (rst),
    .enable         (enable),
    .frame_end      (frame_end),
    .clear_done     (clear_done),
    .cdf_done       (cdf_done),
    .clear_start    (clear_start),
    .ping_pong_flag (ping_pong_flag),
    .stat_en        (stat_en),
    .cdf_start      (cdf_start),
    .cdf_tile_idx   (cdf_tile_idx),
    .busy           (busy),
    .lut_valid      (lut_valid),
    .overrun        (overrun),
    .frame_cnt      (frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // CDF engine model: cdf_done pulse 3 cycles after each cdf_start
  initial begin
    cdf_done = 1'b0;
    cdf_cnt  = 0;
    forever begin
      @(posedge pclk);
      #1;
      cdf_done = 1'b0;
      if (cdf_cnt > 0) begin
        cdf_cnt--;
        if (cdf_cnt == 0) cdf_done = 1'b1;
      end
      if (cdf_start && !rst) cdf_cnt = 3;
    end
  end

  // RAM clear model: after clear_start, clear_done stays 1 for clr_hold
  // cycles, then 0 for clr_low cycles, then returns to 1
  initial begin
    clear_done = 1'b0;
    clr_hcnt   = 0;
    clr_lcnt   = 0;
    forever begin
      @(posedge pclk);
      #1;
      if (clr_force != 0) begin
        clear_done = 1'b0;
        clr_hcnt   = 0;
        clr_lcnt   = 0;
      end else begin
        if (clr_hcnt > 0) begin
          clr_hcnt--;
          clear_done = 1'b1;
        end else if (clr_lcnt > 0) begin
          clr_lcnt--;
          clear_done = 1'b0;
        end else begin
          clear_done = 1'b1;
        end
        if (clear_start) begin
          clr_hcnt = clr_hold;
          clr_lcnt = clr_low;
        end
      end
    end
  end

  // output monitor: pops the scoreboard whenever the DUT produces an event
  initial begin : mon
    logic [16:0] e;
    forever begin
      @(negedge pclk);
      cyc++;
      if (!rst) begin
        if (cdf_start) begin
          cdf_start_cnt++;
          if (exp_tiles.size() == 0) chk("cdf_start_unexpected", 32'd1, 32'd0);
          else chk("cdf_tile_idx", cdf_tile_idx, exp_tiles.pop_front());
        end
        if (clear_start) begin
          clr_since_swap++;
          clr_cyc = cyc;
          chk("clear_before_cdf_done", exp_tiles.size(), 32'd0);
        end
        if (ping_pong_flag !== prev_flag) begin
          if (exp_swaps.size() == 0) begin
            chk("swap_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_swaps.pop_front();
            chk("swap_flag", ping_pong_flag, e[16]);
            chk("swap_frame_cnt", frame_cnt, e[15:0]);
            chk("swap_lut_valid", lut_valid, 32'd1);
            chk("clear_starts_per_frame", clr_since_swap, 32'd1);
            chk("clear_to_swap_cycles", cyc - clr_cyc, clr_hold + clr_low + 3);
          end
          clr_since_swap = 0;
        end
      end
      prev_flag = ping_pong_flag;
    end
  end

  // absolute time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_stat(input int budget);
    int n = 0;
    while (!stat_en && n < budget) begin
      @(negedge pclk);
      n++;
    end
    if (!stat_en) chk("wait_stat_timeout", 32'd0, 32'd1);
  endtask

  // drive one frame_end that the DUT must accept, and queue its results
  task automatic send_frame();
    @(negedge pclk);
    wait_stat(3000);
    frame_end = 1'b1;
    for (int i = 0; i < 64; i++) exp_tiles.push_back(6'(i));
    m_flag = ~m_flag;
    m_fcnt = m_fcnt + 16'd1;
    exp_swaps.push_back({m_flag, m_fcnt});
    @(negedge pclk);
    frame_end = 1'b0;
    chk("stat_en_drop", stat_en, 32'd0);
    chk("busy_on_accept", busy, 32'd1);
  endtask

  task automatic wait_tile_start(input logic [5:0] idx);
    int n = 0;
    while (!(cdf_start && cdf_tile_idx == idx) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    if (!(cdf_start && cdf_tile_idx == idx)) chk("wait_tile_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(exp_swaps.size() == 0 && stat_en) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    chk("pass_complete", (exp_swaps.size() == 0 && stat_en), 32'd1);
  endtask

  initial begin
    int bad_cyc;
    int saved;
    rst            = 1'b1;
    enable         = 1'b1;
    frame_end      = 1'b0;
    clr_force      = 1;
    clr_hold       = 0;
    clr_low        = 4;
    clr_since_swap = 0;
    clr_cyc        = 0;
    cdf_start_cnt  = 0;
    m_flag         = 1'b0;
    m_fcnt         = 16'd0;
    prev_flag      = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_flag", ping_pong_flag, 32'd0);
    chk("rst_stat_en", stat_en, 32'd0);
    chk("rst_cdf_start", cdf_start, 32'd0);
    chk("rst_clear_start", clear_start, 32'd0);
    chk("rst_tile_idx", cdf_tile_idx, 32'd0);
    chk("rst_busy", busy, 32'd1);
    chk("rst_lut_valid", lut_valid, 32'd0);
    chk("rst_overrun", overrun, 32'd0);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    rst = 1'b0;

    // 1: RAM self-clear takes 512 cycles after reset
    bad_cyc = 0;
    repeat (512) begin
      @(negedge pclk);
      if (!busy || stat_en) bad_cyc++;
    end
    chk("init_wait_busy", bad_cyc, 32'd0);
    clr_force = 0;
    begin
      int n = 0;
      while (!clear_done && n < 10) begin
        @(negedge pclk);
        n++;
      end
    end
    chk("init_clear_done_seen", clear_done, 32'd1);
    chk("init_stat_en_still_low", stat_en, 32'd0);
    @(negedge pclk);
    chk("init_stat_en_high", stat_en, 32'd1);
    chk("init_busy_low", busy, 32'd0);

    // 2: normal pass
    chk("lut_valid_before_swap", lut_valid, 32'd0);
    cdf_start_cnt = 0;
    send_frame();
    wait_done(3000);
    chk("pass1_cdf_starts", cdf_start_cnt, 32'd64);
    chk("pass1_flag", ping_pong_flag, 32'd1);
    chk("pass1_frame_cnt", frame_cnt, 32'd1);
    chk("pass1_lut_valid", lut_valid, 32'd1);

    // 3: clear_done lingers high one cycle, then RAM busy for 256 cycles
    clr_hold = 1;
    clr_low  = 256;
    send_frame();
    wait_done(3000);
    clr_hold = 0;
    clr_low  = 4;
    chk("pass2_flag", ping_pong_flag, 32'd0);

    // 4: frame_end at tile 10 is an overrun, pass continues
    cdf_start_cnt = 0;
    send_frame();
    wait_tile_start(6'd10);
    frame_end = 1'b1;
    @(negedge pclk);
    frame_end = 1'b0;
    @(negedge pclk);
    chk("overrun_set", overrun, 32'd1);
    wait_done(3000);
    chk("pass3_cdf_starts", cdf_start_cnt, 32'd64);
    chk("pass3_frame_cnt", frame_cnt, 32'd3);

    // 5: reset during CDF_WAIT at tile 17 with flag=1
    send_frame();
    wait_tile_start(6'd17);
    chk("pre_rst_flag", ping_pong_flag, 32'd1);
    rst       = 1'b1;
    clr_force = 1;
    @(negedge pclk);
    chk("mid_rst_flag", ping_pong_flag, 32'd0);
    chk("mid_rst_tile_idx", cdf_tile_idx, 32'd0);
    chk("mid_rst_lut_valid", lut_valid, 32'd0);
    chk("mid_rst_busy", busy, 32'd1);
    chk("mid_rst_stat_en", stat_en, 32'd0);
    chk("mid_rst_overrun", overrun, 32'd0);
    chk("mid_rst_frame_cnt", frame_cnt, 32'd0);
    exp_tiles.delete();
    exp_swaps.delete();
    m_flag         = 1'b0;
    m_fcnt         = 16'd0;
    clr_since_swap = 0;
    @(negedge pclk);
    rst = 1'b0;
    repeat (20) @(negedge pclk);
    chk("post_rst_init_wait", stat_en, 32'd0);
    clr_force = 0;
    wait_stat(50);

    // 6: enable=0 ignores frame_end, then a normal pass
    enable = 1'b0;
    saved  = cdf_start_cnt;
    repeat (3) begin
      @(negedge pclk);
      wait_stat(50);
      frame_end = 1'b1;
      @(negedge pclk);
      frame_end = 1'b0;
      repeat (5) @(negedge pclk);
    end
    chk("disabled_no_cdf_start", cdf_start_cnt - saved, 32'd0);
    chk("disabled_no_overrun", overrun, 32'd0);
    chk("disabled_stays_stat", stat_en, 32'd1);
    enable = 1'b1;
    send_frame();
    wait_tile_start(6'd5);
    enable = 1'b0;
    wait_done(3000);
    enable = 1'b1;
    chk("pass5_frame_cnt", frame_cnt, 32'd1);
    chk("pass5_flag", ping_pong_flag, 32'd1);
    chk("pass5_lut_valid", lut_valid, 32'd1);
    chk("pass5_overrun", overrun, 32'd0);

    repeat (5) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
